// File: rtl/div_iter.sv
// Multi-cycle restoring divider for DIV/DIVU in the EX stage; returns {remainder, quotient}
// for the HI/LO write path and holds the pipeline while a division is in flight.
module div_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_req
);

    typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic             sign1, sign2, is_signed;

    logic             launch;
    logic [WIDTH-1:0] abs1, abs2;
    logic [WIDTH:0]   shifted, trial;
    logic             step_ok;
    logic [WIDTH-1:0] rem_step, quot_step, rem_fix, quot_fix;

    // One extra trial bit keeps the step correct for divisors above 2^(WIDTH-1),
    // where the shifted partial remainder can exceed WIDTH bits.
    always_comb begin
        launch    = start && !annul && (opdata2 != '0);
        abs1      = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        abs2      = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
        shifted   = {rem, dividend[WIDTH-1]};
        trial     = shifted - {1'b0, divisor};
        step_ok   = ~trial[WIDTH];
        rem_step  = step_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_step = {dividend[WIDTH-2:0], step_ok};
        quot_fix  = (is_signed && (sign1 ^ sign2)) ? -quot_step : quot_step;
        rem_fix   = (is_signed && sign1) ? -rem_step : rem_step;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        stall_req  = 1'b0;
        ready      = 1'b0;
        unique case (state)
            IDLE: begin
                stall_req = start && !annul;
                if (start && !annul)
                    state_next = (opdata2 == '0) ? BYZERO : RUN;
            end
            BYZERO: begin
                stall_req  = 1'b1;
                state_next = annul ? IDLE : DONE;
            end
            RUN: begin
                stall_req = 1'b1;
                if (annul)                  state_next = IDLE;
                else if (cnt == LAST_STEP)  state_next = DONE;
            end
            DONE: begin
                ready = 1'b1;
                if (!start || annul) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The quotient shifts into the dividend register as dividend bits shift out.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dividend  <= '0;
            divisor   <= '0;
            rem       <= '0;
            sign1     <= 1'b0;
            sign2     <= 1'b0;
            is_signed <= 1'b0;
            result    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (launch) begin
                        dividend  <= abs1;
                        divisor   <= abs2;
                        rem       <= '0;
                        cnt       <= '0;
                        sign1     <= opdata1[WIDTH-1];
                        sign2     <= opdata2[WIDTH-1];
                        is_signed <= signed_div;
                    end
                    result <= '0;
                end
                BYZERO: result <= '0;
                RUN: begin
                    if (!annul) begin
                        dividend <= quot_step;
                        rem      <= rem_step;
                        cnt      <= cnt + CNT_W'(1);
                        if (cnt == LAST_STEP)
                            result <= {rem_fix, quot_fix};
                    end
                end
                DONE: begin
                    if (!start || annul)
                        result <= '0;
                end
                default: result <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter: unsigned/signed results, latency,
// divide-by-zero, annul, operand stability and mid-run reset.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_req;

    int checks = 0;
    int errors = 0;

    div_iter #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_req  (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises start with the given operands and waits (bounded) for ready,
    // counting edges taken and cycles with stall_req high.
    task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                           output int edges, output int stalls);
        signed_div = sd;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        edges      = 0;
        stalls     = 0;
        while (!ready && edges < 100) begin
            @(negedge clk);
            if (stall_req) stalls++;
            tick();
            edges++;
        end
    endtask

    task automatic release_start(input string name);
        start = 1'b0;
        tick();
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_drop_ready got %b want 0", name, ready);
        end
        checks++;
        if (result !== 64'h0) begin
            errors++;
            $display("[TB] FAIL %s_drop_result got %h want 0", name, result);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", ready); end
        checks++;
        if (result !== 64'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 0", result); end
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b want 0", stall_req); end
    endtask

    task automatic test_divu();
        int edges, stalls;
        run_div(1'b0, 32'd100, 32'd7, edges, stalls);
        checks++;
        if (edges !== 33) begin errors++; $display("[TB] FAIL divu_latency got %0d want 33", edges); end
        checks++;
        if (stalls !== 33) begin errors++; $display("[TB] FAIL divu_stall_cycles got %0d want 33", stalls); end
        checks++;
        if (result !== 64'h00000002_0000000E) begin
            errors++; $display("[TB] FAIL divu_result got %h want 000000020000000e", result);
        end
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL divu_done_stall got %b want 0", stall_req); end
        release_start("divu");
    endtask

    task automatic test_signed();
        logic        sd_v [5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] a_v  [5]  = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF};
        logic [31:0] b_v  [5]  = '{32'd2, 32'hFFFFFFFE, 32'd1, 32'd2, 32'h80000001};
        logic [63:0] exp_v[5]  = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                                   64'h00000000_FFFFFFFF, 64'h00000001_7FFFFFFC,
                                   64'h7FFFFFFE_00000001};
        int edges, stalls;
        for (int i = 0; i < 5; i++) begin
            run_div(sd_v[i], a_v[i], b_v[i], edges, stalls);
            checks++;
            if (result !== exp_v[i]) begin
                errors++;
                $display("[TB] FAIL signed_vec%0d_result got %h want %h", i, result, exp_v[i]);
            end
            start = 1'b0;
            tick();
        end
    endtask

    task automatic test_overflow_zero();
        int edges, stalls;
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, edges, stalls);
        checks++;
        if (result !== 64'h00000000_80000000) begin
            errors++; $display("[TB] FAIL overflow_result got %h want 0000000080000000", result);
        end
        checks++;
        if (edges !== 33) begin errors++; $display("[TB] FAIL overflow_latency got %0d want 33", edges); end
        release_start("overflow");

        run_div(1'b1, 32'd5, 32'd0, edges, stalls);
        checks++;
        if (edges !== 2) begin errors++; $display("[TB] FAIL byzero_latency got %0d want 2", edges); end
        checks++;
        if (stalls !== 2) begin errors++; $display("[TB] FAIL byzero_stall_cycles got %0d want 2", stalls); end
        checks++;
        if (result !== 64'h0) begin errors++; $display("[TB] FAIL byzero_result got %h want 0", result); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL byzero_ready got %b want 1", ready); end
        release_start("byzero");

        run_div(1'b0, 32'hFFFFFFFF, 32'd0, edges, stalls);
        checks++;
        if (edges !== 2 || result !== 64'h0) begin
            errors++; $display("[TB] FAIL byzero_u edges %0d result %h want 2 and 0", edges, result);
        end
        start = 1'b0;
        tick();
    endtask

    task automatic test_annul();
        int seen = 0;
        int edges, stalls;
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        repeat (11) tick();
        start = 1'b0;
        annul = 1'b1;
        tick();
        annul = 1'b0;
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL annul_stall got %b want 0", stall_req); end
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            errors++; $display("[TB] FAIL annul_idle ready %b result %h want 0 and 0", ready, result);
        end
        repeat (40) begin
            tick();
            if (ready) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("[TB] FAIL annul_no_ready got %0d ready cycles want 0", seen); end

        run_div(1'b0, 32'd100, 32'd7, edges, stalls);
        checks++;
        if (edges !== 33 || result !== 64'h00000002_0000000E) begin
            errors++; $display("[TB] FAIL annul_restart edges %0d result %h want 33 and 000000020000000e", edges, result);
        end
        release_start("annul_restart");
    endtask

    task automatic test_back_to_back_stability();
        int edges = 0;
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        tick();
        edges = 1;
        while (!ready && edges < 100) begin
            opdata1    = $urandom();
            opdata2    = $urandom();
            signed_div = ~signed_div;
            tick();
            edges++;
        end
        checks++;
        if (edges !== 33) begin errors++; $display("[TB] FAIL stable_latency got %0d want 33", edges); end
        checks++;
        if (result !== 64'h00000002_0000000E) begin
            errors++; $display("[TB] FAIL stable_result got %h want 000000020000000e", result);
        end
        for (int i = 0; i < 5; i++) begin
            opdata1 = $urandom();
            tick();
            checks++;
            if (ready !== 1'b1 || result !== 64'h00000002_0000000E) begin
                errors++; $display("[TB] FAIL hold_done%0d ready %b result %h want 1 and 000000020000000e", i, ready, result);
            end
        end
        release_start("hold");
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        repeat (21) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            errors++; $display("[TB] FAIL midreset_clear ready %b result %h want 0 and 0", ready, result);
        end
        checks++;
        if (stall_req !== 1'b1) begin errors++; $display("[TB] FAIL midreset_stall got %b want 1", stall_req); end
        start = 1'b0;
        repeat (40) begin
            tick();
            if (ready || result !== 64'h0) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("[TB] FAIL midreset_stale got %0d bad cycles want 0", seen); end
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL midreset_idle_stall got %b want 0", stall_req); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_overflow_zero();
        test_annul();
        test_back_to_back_stability();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
